mem_rmw_initiator: RTL and testbench

- Initiator side of the single-port word-wide instruction/data memory used by the multi-cycle CPU.
- Accepts byte, halfword and word load/store requests from the CPU datapath through a valid/ready handshake.
- Drives the memory's Address, Write_data, MemRead and MemWrite controls, and consumes its combinational read data.
- Sub-word stores use read-modify-write, because the memory only writes whole words. Sub-word loads are extracted and extended here.

---
 rtl/mem_rmw_initiator.sv | 168 ++++++++++++++++
 tb/tb_mem_rmw_initiator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rmw_initiator.sv
// Memory initiator for the multi-cycle CPU: byte/half/word loads and stores
// over a word-only single-port memory. Sub-word stores are read-modify-write.
// Sub-word loads are extracted and extended here.
module mem_rmw_initiator #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    state_e      r_state;
    // Latched request fields; only what RD/WR still need after acceptance.
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [15:0] r_wdata_lo;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_err;
    logic [31:0] w_merge;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Classify the incoming request as illegal, misaligned or out of range.
    always_comb begin
        w_err = 1'b0;
        if (req_size == 2'b11)                           w_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])            w_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) w_err = 1'b1;
        if (req_addr >= ADDR_LIMIT)                      w_err = 1'b1;
    end

    // Merge the store lane(s) into the word being read during RD.
    always_comb begin
        w_merge = mem_rdata;
        if (r_size == 2'b00) begin
            w_merge[{r_off, 3'b000} +: 8] = r_wdata_lo[7:0];
        end else if (r_off[1]) begin
            w_merge[31:16] = r_wdata_lo;
        end else begin
            w_merge[15:0] = r_wdata_lo;
        end
    end

    // Extract and extend the addressed lane for loads.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // Request FSM with registered memory and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_off        <= 2'b00;
            r_wdata_lo   <= 16'h0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            // Pulsed outputs default low; mem_addr holds the last address.
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_off       <= req_addr[1:0];
                        r_wdata_lo  <= req_wdata[15:0];
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_req_ready <= 1'b0;
                        if (w_err) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (req_write && req_size == 2'b10) begin
                            r_state     <= StWr;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= req_wdata;
                        end else begin
                            r_state    <= StRd;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    if (r_write) begin
                        r_state     <= StWr;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merge;
                    end else begin
                        r_state      <= StResp;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                    end
                end
                StWr: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                end
                StResp: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;

endmodule

// File: tb/tb_mem_rmw_initiator.sv
// Directed bench for mem_rmw_initiator with a word-wide memory model.
module tb_mem_rmw_initiator;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_tests;
    int n_fail;

    // Per-transaction observations
    int          t_lat;
    int          t_rd;
    int          t_wr;
    logic [31:0] t_wa;
    logic [31:0] t_wd;
    logic [31:0] t_rdata;
    logic        t_err;

    mem_rmw_initiator #(.ADDR_LIMIT(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read port, synchronous write port.
    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch until resp_valid (bounded).
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        int k;
        logic got;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clk);
        #1;
        // Scramble inputs: the block must have latched everything.
        req_valid  = 1'b0;
        req_write  = ~w;
        req_size   = 2'b11;
        req_signed = ~sg;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = ~d;
        t_lat = 0; t_rd = 0; t_wr = 0;
        t_wa = 32'h0; t_wd = 32'h0; t_rdata = 32'h0; t_err = 1'b0;
        got = 1'b0;
        while (!got && t_lat < 8) begin
            @(negedge clk);
            t_lat++;
            if (mem_read) t_rd++;
            if (mem_write) begin
                t_wr++;
                t_wa = mem_addr;
                t_wd = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1;
                t_rdata = resp_rdata;
                t_err = resp_err;
            end
        end
        if (!got) t_lat = 99;
    endtask

    task automatic txn(input string tag, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] rdata, input logic err,
                       input int rd, input int wr);
        issue(w, sz, sg, a, d);
        chk({tag, "_lat"}, 32'(t_lat), 32'(lat));
        chk({tag, "_rdata"}, t_rdata, rdata);
        chk({tag, "_err"}, {31'h0, t_err}, {31'h0, err});
        chk({tag, "_rdcnt"}, 32'(t_rd), 32'(rd));
        chk({tag, "_wrcnt"}, 32'(t_wr), 32'(wr));
        // One-cycle response pulse, ready again right after RESP.
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        int bad;
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rvalid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rerr", {31'h0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mrd", {31'h0, mem_read}, 32'h0);
        chk("rst_mwr", {31'h0, mem_write}, 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Word store then load
        txn("sw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
        chk("sw80_wa", t_wa, 32'h80);
        chk("sw80_wd", t_wd, 32'hDEADBEEF);
        txn("lw80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // Byte store RMW
        txn("sw90", 1'b1, 2'b10, 1'b0, 32'h90, 32'h11223344, 2, 32'h0, 1'b0, 0, 1);
        txn("sb91", 1'b1, 2'b00, 1'b0, 32'h91, 32'h0000005A, 3, 32'h0, 1'b0, 1, 1);
        chk("sb91_wa", t_wa, 32'h90);
        chk("sb91_wd", t_wd, 32'h11225A44);
        txn("lw90", 1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 2, 32'h11225A44, 1'b0, 1, 0);

        // Sub-word loads
        txn("swA0", 1'b1, 2'b10, 1'b0, 32'hA0, 32'h80F0FF7F, 2, 32'h0, 1'b0, 0, 1);
        txn("lbA0", 1'b0, 2'b00, 1'b1, 32'hA0, 32'h0, 2, 32'h0000007F, 1'b0, 1, 0);
        txn("lbA1", 1'b0, 2'b00, 1'b1, 32'hA1, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 1, 0);
        txn("lbuA1", 1'b0, 2'b00, 1'b0, 32'hA1, 32'h0, 2, 32'h000000FF, 1'b0, 1, 0);
        txn("lbuA3", 1'b0, 2'b00, 1'b0, 32'hA3, 32'h0, 2, 32'h00000080, 1'b0, 1, 0);
        txn("lhA2", 1'b0, 2'b01, 1'b1, 32'hA2, 32'h0, 2, 32'hFFFF80F0, 1'b0, 1, 0);
        txn("lhuA2", 1'b0, 2'b01, 1'b0, 32'hA2, 32'h0, 2, 32'h000080F0, 1'b0, 1, 0);

        // Error requests
        txn("e_w82", 1'b0, 2'b10, 1'b0, 32'h82, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("e_h83", 1'b1, 2'b01, 1'b0, 32'h83, 32'h1234, 1, 32'h0, 1'b1, 0, 0);
        txn("e_sz3", 1'b0, 2'b11, 1'b0, 32'h80, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        txn("e_lim", 1'b1, 2'b10, 1'b0, 32'h400, 32'h1, 1, 32'h0, 1'b1, 0, 0);

        // Last legal word
        txn("sw3FC", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h12345678, 2, 32'h0, 1'b0, 0, 1);
        txn("lw3FC", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 2, 32'h12345678, 1'b0, 1, 0);

        // Half store into upper half of a zero word
        txn("sw84", 1'b1, 2'b10, 1'b0, 32'h84, 32'h00000000, 2, 32'h0, 1'b0, 0, 1);
        txn("sh86", 1'b1, 2'b01, 1'b0, 32'h86, 32'hFFFFABCD, 3, 32'h0, 1'b0, 1, 1);
        chk("sh86_wa", t_wa, 32'h84);
        chk("sh86_wd", t_wd, 32'hABCD0000);

        // Reset during RD of a byte store
        txn("swB0", 1'b1, 2'b10, 1'b0, 32'hB0, 32'h55667788, 2, 32'h0, 1'b0, 0, 1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'hB2; req_wdata = 32'hEE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rmid_inrd", {31'h0, mem_read}, 32'h1);
        #2;
        reset = 1'b1;
        bad = 0;
        #1;
        if (mem_write || resp_valid) bad++;
        repeat (3) begin
            @(negedge clk);
            if (mem_write || resp_valid) bad++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_write || resp_valid) bad++;
        end
        chk("rmid_nopulse", 32'(bad), 32'h0);
        chk("rmid_ready", {31'h0, req_ready}, 32'h1);
        txn("lwB0", 1'b0, 2'b10, 1'b0, 32'hB0, 32'h0, 2, 32'h55667788, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
